aclk_load_arbiter: RTL

ACLK_LOAD_ARBITER -- requirements
Module: aclk_load_arbiter

---
 rtl/aclk_load_arbiter.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/aclk_load_arbiter.sv
// Arbitrates two time/alarm load requesters and a snooze request onto the
// digit/LD interface of a BCD alarm clock, with round-robin fairness.
module aclk_load_arbiter #(
  parameter int unsigned HOLD_CYCLES = 2,
  parameter int unsigned SNOOZE_MIN  = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        r0_req,
  input  logic        r1_req,
  input  logic        r0_alarm,
  input  logic        r1_alarm,
  input  logic [13:0] r0_time,
  input  logic [13:0] r1_time,
  output logic        r0_ack,
  output logic        r1_ack,
  output logic        r0_err,
  output logic        r1_err,
  input  logic        snooze_req,
  output logic        snooze_ack,
  input  logic        Alarm,
  input  logic [1:0]  H_out1,
  input  logic [3:0]  H_out0,
  input  logic [3:0]  M_out1,
  input  logic [3:0]  M_out0,
  output logic [1:0]  H_in1,
  output logic [3:0]  H_in0,
  output logic [3:0]  M_in1,
  output logic [3:0]  M_in0,
  output logic        LD_time,
  output logic        LD_alarm,
  output logic        STOP_al,
  output logic        busy
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_DONE     = 3'd2,
    ST_REJECT   = 3'd3,
    ST_SNZ_STOP = 3'd4
  } state_t;

  state_t      state_r;
  logic [13:0] cap_time_r;
  logic        cap_idx_r;
  logic        cap_snz_r;
  logic        last_r;
  logic        snz_pend_r;
  logic [3:0]  hold_cnt_r;

  logic        gnt_any_s;
  logic        gnt_idx_s;
  logic        gnt_alarm_s;
  logic [13:0] gnt_time_s;

  function automatic logic time_valid(input logic [13:0] t);
    logic [1:0] h1;
    logic [3:0] h0, m1, m0;
    {h1, h0, m1, m0} = t;
    time_valid = (h1 <= 2'd2) && (h0 <= 4'd9) && (m1 <= 4'd5) && (m0 <= 4'd9) &&
                 !((h1 == 2'd2) && (h0 > 4'd3));
  endfunction

  // Current time plus SNOOZE_MIN minutes, wrapping at 24 h, re-encoded as BCD.
  function automatic logic [13:0] snooze_target(input logic [1:0] h1, input logic [3:0] h0,
                                                input logic [3:0] m1, input logic [3:0] m0);
    logic [6:0] mins;
    logic [5:0] hrs;
    mins = 7'(m1) * 7'd10 + 7'(m0) + 7'(SNOOZE_MIN);
    hrs  = 6'(h1) * 6'd10 + 6'(h0);
    if (mins >= 7'd60) begin
      mins = mins - 7'd60;
      hrs  = hrs + 6'd1;
    end else begin
      mins = mins;
    end
    if (hrs >= 6'd24) begin
      hrs = hrs - 6'd24;
    end else begin
      hrs = hrs;
    end
    snooze_target = {2'(hrs / 6'd10), 4'(hrs % 6'd10), 4'(mins / 7'd10), 4'(mins % 7'd10)};
  endfunction

  // Round-robin pick: on a tie the requester not granted last wins.
  always_comb begin
    gnt_any_s = r0_req | r1_req;
    if (r0_req && r1_req) begin
      gnt_idx_s = ~last_r;
    end else if (r1_req) begin
      gnt_idx_s = 1'b1;
    end else begin
      gnt_idx_s = 1'b0;
    end
    gnt_time_s  = gnt_idx_s ? r1_time  : r0_time;
    gnt_alarm_s = gnt_idx_s ? r1_alarm : r0_alarm;
  end

  assign busy = (state_r != ST_IDLE);

  // Arbiter FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      cap_time_r <= 14'd0;
      cap_idx_r  <= 1'b0;
      cap_snz_r  <= 1'b0;
      last_r     <= 1'b1;
      snz_pend_r <= 1'b0;
      hold_cnt_r <= 4'd0;
      r0_ack     <= 1'b0;
      r1_ack     <= 1'b0;
      r0_err     <= 1'b0;
      r1_err     <= 1'b0;
      snooze_ack <= 1'b0;
      {H_in1, H_in0, M_in1, M_in0} <= 14'd0;
      LD_time    <= 1'b0;
      LD_alarm   <= 1'b0;
      STOP_al    <= 1'b0;
    end else begin
      r0_ack     <= 1'b0;
      r1_ack     <= 1'b0;
      r0_err     <= 1'b0;
      r1_err     <= 1'b0;
      snooze_ack <= 1'b0;
      STOP_al    <= 1'b0;
      if (snooze_req) begin
        snz_pend_r <= 1'b1;
      end else begin
        snz_pend_r <= snz_pend_r;
      end
      case (state_r)
        ST_IDLE: begin
          if (snz_pend_r) begin
            // A fresh pulse arriving while the old one is served stays pending.
            if (!snooze_req) begin
              snz_pend_r <= 1'b0;
            end else begin
              snz_pend_r <= 1'b1;
            end
            if (Alarm) begin
              state_r    <= ST_SNZ_STOP;
              STOP_al    <= 1'b1;
              cap_snz_r  <= 1'b1;
              cap_time_r <= snooze_target(H_out1, H_out0, M_out1, M_out0);
            end else begin
              state_r <= ST_IDLE;
            end
          end else if (gnt_any_s) begin
            cap_time_r <= gnt_time_s;
            cap_idx_r  <= gnt_idx_s;
            cap_snz_r  <= 1'b0;
            last_r     <= gnt_idx_s;
            if (time_valid(gnt_time_s)) begin
              state_r    <= ST_LOAD;
              hold_cnt_r <= 4'd1;
              LD_time    <= ~gnt_alarm_s;
              LD_alarm   <= gnt_alarm_s;
              {H_in1, H_in0, M_in1, M_in0} <= gnt_time_s;
            end else begin
              state_r <= ST_REJECT;
              r0_err  <= ~gnt_idx_s;
              r1_err  <= gnt_idx_s;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          if (hold_cnt_r >= 4'(HOLD_CYCLES)) begin
            state_r    <= ST_DONE;
            LD_time    <= 1'b0;
            LD_alarm   <= 1'b0;
            {H_in1, H_in0, M_in1, M_in0} <= 14'd0;
            snooze_ack <= cap_snz_r;
            r0_ack     <= ~cap_snz_r & ~cap_idx_r;
            r1_ack     <= ~cap_snz_r & cap_idx_r;
          end else begin
            hold_cnt_r <= hold_cnt_r + 4'd1;
          end
        end
        ST_SNZ_STOP: begin
          state_r    <= ST_LOAD;
          hold_cnt_r <= 4'd1;
          LD_alarm   <= 1'b1;
          {H_in1, H_in0, M_in1, M_in0} <= cap_time_r;
        end
        ST_DONE:   state_r <= ST_IDLE;
        ST_REJECT: state_r <= ST_IDLE;
        default:   state_r <= ST_IDLE;
      endcase
    end
  end

endmodule
